xoodoo_perm_arbiter: RTL and testbench
======================================

# xoodoo_perm_arbiter

Round-robin controller that shares a single XOODOO permutation core between `N_REQ` requesters, typically several XOODYAK sponge engines. It arbitrates pending requests, launches the core with the winner's 384-bit state and waits for the core's completion. It then returns the permuted state to that requester only. A watchdog ends any permutation that never completes and reports an error, so no requester can deadlock the shared core.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `STATE_W`, 384: permutation state width.
- `TIMEOUT`, 64: maximum BUSY cycles before the watchdog fires. Must be at least 1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  request per requester. Held high until that requester's `gnt` pulse.
- `req_state`  in  N_REQ*STATE_W  requester i's state on bits [i*STATE_W +: STATE_W].
- `gnt`  out  N_REQ  one-hot, 1-cycle pulse. The input state has been captured.
- `rsp_valid`  out  N_REQ  one-hot, 1-cycle pulse. `rsp_state`/`rsp_err` are valid for that requester.
- `rsp_state`  out  STATE_W  permuted state. Shared by all requesters; qualified by `rsp_valid`.
- `rsp_err`  out  1  watchdog fired. Qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  clog2(N_REQ)  index of the current/last granted requester.
- `xoodoo_enable`  out  1  1-cycle start pulse to the core.
- `xoodoo_state_out`  out  STATE_W  state to the core. Stable from ISSUE until the end of BUSY.
- `xoodoo_state_in`  in  STATE_W  core result. Valid in the cycle `xoodoo_done`=1.
- `xoodoo_done`  in  1  core completion pulse.

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESP.
- **IDLE**
  - If any `req` bit is high, pick the first set bit scanning upward from `last+1` (mod N_REQ).
  - Register the winner into `owner` and `last`, latch that requester's `req_state` into the state register, then go to ISSUE.
  - If no `req` bit is high, stay in IDLE.
- **ISSUE** (1 cycle)
  - `gnt[owner]`=1 and `xoodoo_enable`=1. `xoodoo_state_out` = latched state.
  - Clear the watchdog counter and go to BUSY.
- **BUSY**
  - If `xoodoo_done`=1: capture `xoodoo_state_in` into `rsp_state`, clear the error flag, go to RESP.
  - Otherwise, if the counter equals TIMEOUT-1: copy the latched input state into `rsp_state`, set the error flag, go to RESP.
  - Otherwise increment the counter.
  - If `xoodoo_done` and the timeout condition occur in the same cycle, `xoodoo_done` wins and `rsp_err`=0.
- **RESP** (1 cycle)
  - `rsp_valid[owner]`=1 and `rsp_err` is driven from the error flag. Go to IDLE.
- Round-robin rules:
  - `last` resets to N_REQ-1, so requester 0 wins first after reset.
  - Fairness holds even when a requester keeps `req` high continuously.
- `xoodoo_done` is ignored in IDLE, ISSUE and RESP. This covers a late `done` arriving after a timeout.
- A `req` dropped before its `gnt` withdraws the request. It has no other effect.
- `rsp_state` and `owner` hold their values until the next capture.
- Watchdog counter width is clog2(TIMEOUT+1) and never wraps.

## Timing
- Reset values: `gnt`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_state`=0, `busy`=0, `owner`=0, `xoodoo_enable`=0, `xoodoo_state_out`=0. FSM=IDLE, counter=0, `last`=N_REQ-1.
- Reset asserted in any state returns the block to these values on the next edge. No `rsp_valid` is issued for the aborted transfer.
- Example sequence, with `req` high at edge t in IDLE:
  - `gnt` and `xoodoo_enable` are high in cycle t+1.
  - BUSY begins at t+2.
  - If `xoodoo_done` is sampled at edge d, `rsp_valid` is high in cycle d+1.
  - The block is in IDLE at d+2; the next `gnt` appears at d+3 at the earliest.
- Overhead: 3 cycles of controller overhead plus the core latency.
- Watchdog: with no `done`, RESP occurs exactly TIMEOUT BUSY cycles after ISSUE.
- All outputs are registered. There is no combinational path from `req` to `gnt`.

## Test plan
- **Single request:** `req`=01 with state 0x…0102 and a core model that returns its input XOR 1 after 12 cycles.
  - `gnt`=01 one cycle after the request.
  - `rsp_valid`=01 with state 0x…0103 and `rsp_err`=0.
  - `rsp_valid` falls 3 cycles after `done` minus 1 cycle of registration (i.e. `done` at d, `rsp_valid` at d+1).
- **Simultaneous requests after reset:** `req`=11.
  - Grant order is requester 0, then 1.
  - Each requester receives only its own result.
- **Fairness:** both `req` held high for 6 permutations.
  - `gnt` alternates 01,10,01,10,01,10.
- **Watchdog:** TIMEOUT=8 and the core never asserts `done`.
  - `rsp_valid` arrives 8 cycles after ISSUE with `rsp_err`=1 and `rsp_state` equal to the input state.
  - A `done` injected 2 cycles later produces no response.
- **Reset mid-BUSY:** assert reset during BUSY.
  - All outputs are 0 on the next cycle and no `rsp_valid` is produced.
  - The next request from requester 1 alone is granted and completes normally.
- **Same-cycle done and timeout:** `done` arrives exactly on the timeout cycle.
  - `rsp_err`=0 and `rsp_state` equals the core result.

Source files
------------

// File: rtl/xoodoo_perm_arbiter.sv
// Round-robin arbiter sharing one XOODOO permutation core between N_REQ requesters,
// with a watchdog that ends any permutation the core never completes.
module xoodoo_perm_arbiter #(
  parameter int N_REQ   = 2,
  parameter int STATE_W = 384,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*STATE_W-1:0]   req_state,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [STATE_W-1:0]         rsp_state,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       xoodoo_enable,
  output logic [STATE_W-1:0]         xoodoo_state_out,
  input  logic [STATE_W-1:0]         xoodoo_state_in,
  input  logic                       xoodoo_done
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} fsm_t;

  fsm_t               state, state_next;
  logic [OW-1:0]      last, last_next, owner_next;
  logic [CW-1:0]      wd_cnt, wd_cnt_next;
  logic [N_REQ-1:0]   gnt_next, rsp_valid_next;
  logic [STATE_W-1:0] rsp_state_next, latch_next, pick_state;
  logic               rsp_err_next, busy_next, enable_next;
  logic               found_hi, found_lo;
  logic [OW-1:0]      pick, pick_hi, pick_lo;

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) v[i] = (OW'(i) == idx);
    return v;
  endfunction

  // Round-robin: lowest requester above last wins, otherwise wrap to the lowest at or below it.
  always_comb begin
    found_hi   = 1'b0;
    found_lo   = 1'b0;
    pick_hi    = '0;
    pick_lo    = '0;
    pick_state = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (OW'(i) > last) && !found_hi) begin
        found_hi = 1'b1;
        pick_hi  = OW'(i);
      end
      if (req[i] && (OW'(i) <= last) && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = OW'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
    for (int i = 0; i < N_REQ; i++) begin
      if (OW'(i) == pick) pick_state = req_state[i*STATE_W +: STATE_W];
    end
  end

  always_comb begin
    state_next     = state;
    last_next      = last;
    owner_next     = owner;
    wd_cnt_next    = wd_cnt;
    gnt_next       = '0;
    rsp_valid_next = '0;
    rsp_state_next = rsp_state;
    rsp_err_next   = rsp_err;
    enable_next    = 1'b0;
    latch_next     = xoodoo_state_out;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next  = ISSUE;
          owner_next  = pick;
          last_next   = pick;
          latch_next  = pick_state;
          gnt_next    = onehot(pick);
          enable_next = 1'b1;
        end
      end
      ISSUE: begin
        wd_cnt_next = '0;
        state_next  = BUSY;
      end
      BUSY: begin
        // A done arriving on the timeout cycle takes priority over the watchdog.
        if (xoodoo_done) begin
          rsp_state_next = xoodoo_state_in;
          rsp_err_next   = 1'b0;
          rsp_valid_next = onehot(owner);
          state_next     = RESP;
        end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
          rsp_state_next = xoodoo_state_out;
          rsp_err_next   = 1'b1;
          rsp_valid_next = onehot(owner);
          state_next     = RESP;
        end else begin
          wd_cnt_next = wd_cnt + CW'(1);
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      last             <= OW'(N_REQ - 1);
      owner            <= '0;
      wd_cnt           <= '0;
      gnt              <= '0;
      rsp_valid        <= '0;
      rsp_state        <= '0;
      rsp_err          <= 1'b0;
      busy             <= 1'b0;
      xoodoo_enable    <= 1'b0;
      xoodoo_state_out <= '0;
    end else begin
      state            <= state_next;
      last             <= last_next;
      owner            <= owner_next;
      wd_cnt           <= wd_cnt_next;
      gnt              <= gnt_next;
      rsp_valid        <= rsp_valid_next;
      rsp_state        <= rsp_state_next;
      rsp_err          <= rsp_err_next;
      busy             <= busy_next;
      xoodoo_enable    <= enable_next;
      xoodoo_state_out <= latch_next;
    end
  end

endmodule

// File: tb/tb_xoodoo_perm_arbiter.sv
// Directed bench: one arbiter with a 12-cycle core model, a second with TIMEOUT=8
// and a hand-driven core for the watchdog cases.
module tb_xoodoo_perm_arbiter;
  localparam int W        = 384;
  localparam int T_MAIN   = 64;
  localparam int T_WD     = 8;
  localparam int CORE_LAT = 12;

  localparam logic [W-1:0] S0  = 384'h0102;
  localparam logic [W-1:0] S1  = {16{24'hC0FFEE}};
  localparam logic [W-1:0] SW0 = {12{32'hDEADBEEF}};
  localparam logic [W-1:0] SW1 = {6{64'h0123456789ABCDEF}};

  logic clk = 1'b0;
  logic reset;

  logic [1:0]     req, gnt, rsp_valid;
  logic [2*W-1:0] req_state;
  logic [W-1:0]   rsp_state, state_out;
  logic [W-1:0]   state_in = '0;
  logic           rsp_err, busy, owner, enable;
  logic           done = 1'b0;

  logic [1:0]     w_req, w_gnt, w_rsp_valid;
  logic [2*W-1:0] w_req_state;
  logic [W-1:0]   w_rsp_state, w_state_out, w_state_in;
  logic           w_rsp_err, w_busy, w_owner, w_enable, w_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xoodoo_perm_arbiter #(.N_REQ(2), .STATE_W(W), .TIMEOUT(T_MAIN)) dut (
    .clk(clk), .reset(reset), .req(req), .req_state(req_state),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_state(rsp_state), .rsp_err(rsp_err),
    .busy(busy), .owner(owner), .xoodoo_enable(enable),
    .xoodoo_state_out(state_out), .xoodoo_state_in(state_in), .xoodoo_done(done)
  );

  xoodoo_perm_arbiter #(.N_REQ(2), .STATE_W(W), .TIMEOUT(T_WD)) dut_wd (
    .clk(clk), .reset(reset), .req(w_req), .req_state(w_req_state),
    .gnt(w_gnt), .rsp_valid(w_rsp_valid), .rsp_state(w_rsp_state), .rsp_err(w_rsp_err),
    .busy(w_busy), .owner(w_owner), .xoodoo_enable(w_enable),
    .xoodoo_state_out(w_state_out), .xoodoo_state_in(w_state_in), .xoodoo_done(w_done)
  );

  // Core model: captures the state on enable, returns it XOR 1 with done CORE_LAT cycles later.
  int           core_cnt = 0;
  logic [W-1:0] core_hold = '0;
  always @(negedge clk) begin
    done = 1'b0;
    if (reset) begin
      core_cnt = 0;
    end else if (enable) begin
      core_hold = state_out;
      core_cnt  = CORE_LAT;
    end else if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        state_in = core_hold ^ W'(1);
        done     = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [W-1:0] st0, input logic [W-1:0] st1);
    req       = r;
    req_state = {st1, st0};
  endtask

  task automatic waitMain(input bit for_gnt, output int ticks);
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while (((for_gnt ? gnt : rsp_valid) == 2'b00) && ticks < 60);
  endtask

  task automatic waitWd(output int ticks);
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while ((w_rsp_valid == 2'b00) && ticks < 60);
  endtask

  initial begin
    int         t;
    logic [1:0] acc;
    logic [1:0] exp_g;

    reset       = 1'b1;
    applyStimulus(2'b00, '0, '0);
    w_req       = 2'b00;
    w_req_state = '0;
    w_state_in  = '0;
    w_done      = 1'b0;
    repeat (3) tick();

    $display("[TB] reset values");
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_rsp_state", rsp_state, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_enable", enable, 0);
    checkOutput("rst_state_out", state_out, 0);
    reset = 1'b0;

    $display("[TB] single request");
    applyStimulus(2'b01, S0, '0);
    tick();
    checkOutput("t1_gnt", gnt, 2'b01);
    checkOutput("t1_enable", enable, 1);
    checkOutput("t1_state_out", state_out, S0);
    checkOutput("t1_busy", busy, 1);
    applyStimulus(2'b00, S0, '0);
    waitMain(1'b0, t);
    checkOutput("t1_rsp_valid", rsp_valid, 2'b01);
    checkOutput("t1_latency", W'(t), W'(CORE_LAT + 1));
    checkOutput("t1_done_same_edge", done, 1);
    checkOutput("t1_rsp_state", rsp_state, 384'h0103);
    checkOutput("t1_rsp_err", rsp_err, 0);
    tick();
    checkOutput("t1_rsp_valid_drop", rsp_valid, 0);
    checkOutput("t1_idle_busy", busy, 0);
    checkOutput("t1_rsp_state_hold", rsp_state, 384'h0103);

    $display("[TB] simultaneous requests after reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(2'b11, S0, S1);
    tick();
    checkOutput("t2_gnt0", gnt, 2'b01);
    checkOutput("t2_owner0", owner, 0);
    checkOutput("t2_state_out0", state_out, S0);
    applyStimulus(2'b10, S0, S1);
    waitMain(1'b0, t);
    checkOutput("t2_rsp_valid0", rsp_valid, 2'b01);
    checkOutput("t2_rsp_state0", rsp_state, S0 ^ W'(1));
    waitMain(1'b1, t);
    checkOutput("t2_gnt1", gnt, 2'b10);
    checkOutput("t2_gnt_gap", W'(t), W'(2));
    checkOutput("t2_owner1", owner, 1);
    checkOutput("t2_state_out1", state_out, S1);
    applyStimulus(2'b00, S0, S1);
    waitMain(1'b0, t);
    checkOutput("t2_rsp_valid1", rsp_valid, 2'b10);
    checkOutput("t2_rsp_state1", rsp_state, S1 ^ W'(1));

    $display("[TB] fairness with both requests held");
    applyStimulus(2'b11, S0, S1);
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      waitMain(1'b1, t);
      checkOutput($sformatf("t3_gnt%0d", i), gnt, exp_g);
      if (i == 5) applyStimulus(2'b00, S0, S1);
      waitMain(1'b0, t);
      checkOutput($sformatf("t3_rsp_valid%0d", i), rsp_valid, exp_g);
      checkOutput($sformatf("t3_rsp_state%0d", i), rsp_state, ((i % 2 == 0) ? S0 : S1) ^ W'(1));
    end

    $display("[TB] watchdog with no done");
    w_req       = 2'b01;
    w_req_state = {SW1, SW0};
    tick();
    checkOutput("t4_gnt", w_gnt, 2'b01);
    checkOutput("t4_enable", w_enable, 1);
    checkOutput("t4_owner", w_owner, 0);
    checkOutput("t4_state_out", w_state_out, SW0);
    w_req = 2'b00;
    waitWd(t);
    checkOutput("t4_rsp_valid", w_rsp_valid, 2'b01);
    // ISSUE cycle plus TIMEOUT BUSY cycles separate the grant from the response.
    checkOutput("t4_latency", W'(t), W'(T_WD + 1));
    checkOutput("t4_rsp_err", w_rsp_err, 1);
    checkOutput("t4_rsp_state", w_rsp_state, SW0);
    tick();
    tick();
    w_done     = 1'b1;
    w_state_in = ~SW0;
    tick();
    w_done = 1'b0;
    acc    = 2'b00;
    repeat (6) begin
      acc = acc | w_rsp_valid;
      tick();
    end
    checkOutput("t4_late_done_no_rsp", acc, 0);
    checkOutput("t4_late_done_idle", w_busy, 0);

    $display("[TB] done on the timeout cycle");
    w_req = 2'b10;
    tick();
    checkOutput("t5_gnt", w_gnt, 2'b10);
    w_req = 2'b00;
    acc   = 2'b00;
    repeat (T_WD) begin
      tick();
      acc = acc | w_rsp_valid;
    end
    checkOutput("t5_no_early_rsp", acc, 0);
    w_done     = 1'b1;
    w_state_in = ~SW1;
    tick();
    w_done = 1'b0;
    checkOutput("t5_rsp_valid", w_rsp_valid, 2'b10);
    checkOutput("t5_rsp_err", w_rsp_err, 0);
    checkOutput("t5_rsp_state", w_rsp_state, ~SW1);

    $display("[TB] reset during BUSY");
    applyStimulus(2'b01, S0, S1);
    tick();
    checkOutput("t6_gnt", gnt, 2'b01);
    applyStimulus(2'b00, S0, S1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_gnt_rst", gnt, 0);
    checkOutput("t6_rsp_valid_rst", rsp_valid, 0);
    checkOutput("t6_rsp_state_rst", rsp_state, 0);
    checkOutput("t6_busy_rst", busy, 0);
    checkOutput("t6_enable_rst", enable, 0);
    checkOutput("t6_state_out_rst", state_out, 0);
    checkOutput("t6_owner_rst", owner, 0);
    acc = 2'b00;
    repeat (20) begin
      tick();
      acc = acc | rsp_valid;
    end
    checkOutput("t6_no_aborted_rsp", acc, 0);
    applyStimulus(2'b10, S0, S1);
    waitMain(1'b1, t);
    checkOutput("t6_gnt1", gnt, 2'b10);
    applyStimulus(2'b00, S0, S1);
    waitMain(1'b0, t);
    checkOutput("t6_rsp_valid1", rsp_valid, 2'b10);
    checkOutput("t6_rsp_state1", rsp_state, S1 ^ W'(1));
    checkOutput("t6_rsp_err1", rsp_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
